multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: opcode  in  6  instruction opcode from instruction register bits [31:26].
REQ-004 SHALL have ports: zero  in  1  ALU zero flag.
REQ-005 SHALL have ports: mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
REQ-006 SHALL have control outputs, each 1 bit: pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, ext_sel.
REQ-007 SHALL have 2-bit control outputs: alu_src_b, alu_op and pc_src.
REQ-008 SHALL have outputs: state  out  4  current state code; illegal  out  1  one-cycle pulse on an undecodable opcode.

Function
REQ-009 SHALL be a Moore FSM with the following states, encoded in this order: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-010 SHALL handle FETCH as follows:
- mem_read=1, alu_src_b=01 (+4), alu_op=00, pc_src=00.
- ir_write and pc_en SHALL be 1 only when mem_ready=1; the FSM stays in FETCH while mem_ready=0.
REQ-011 SHALL handle DECODE as follows:
- alu_src_b=11 (extended immediate shifted left by 2), alu_op=00.
- Next state by opcode: 0x23/0x2B to MEMADR; 0x00 to RTYPEEX; 0x04 to BEQEX; 0x08 to ADDIEX; 0x02 to JEX; any other opcode to FETCH with illegal=1 for that cycle.
REQ-012 SHALL handle MEMADR as follows:
- alu_src_a=1, alu_src_b=10, alu_op=00.
- Next state: 0x23 to MEMRD, otherwise MEMWR.
REQ-013 SHALL handle MEMRD and MEMWR as follows:
- i_or_d=1, with mem_read=1 (MEMRD) or mem_write=1 (MEMWR).
- Each state holds while mem_ready=0.
- On mem_ready=1, MEMRD goes to MEMWB and MEMWR goes to FETCH.
REQ-014 SHALL handle MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-015 SHALL handle RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10; then RTYPEWB.
REQ-016 SHALL handle RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-017 SHALL handle BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; then FETCH.
REQ-018 SHALL handle ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
REQ-019 SHALL handle ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-020 SHALL handle JEX: pc_src=10, pc_en=1; then FETCH.
REQ-021 SHALL drive every output not listed for a state to 0. ext_sel SHALL be 0 (sign extension) except where REQ-027 applies.
REQ-022 SHALL sample opcode only in DECODE and MEMADR. Opcode changes in other states SHALL have no effect.
REQ-023 SHALL drive outputs combinationally from state (and from mem_ready/zero where stated), with no added latency. Instruction cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-024 SHALL treat an unused state code (12-15) as FETCH on the next edge, with all outputs 0 while in that code.

Reset
REQ-025 SHALL, while reset=1, asynchronously force state=FETCH, force illegal=0, and hold all gated outputs (pc_en, ir_write) at 0 regardless of mem_ready.
REQ-026 SHALL abandon any in-progress instruction when reset is asserted, including a pending memory handshake. After release, the first clk edge with mem_ready=1 completes a FETCH.

Configuration
REQ-027 SHALL compile in zero-extended logical immediates only when macro ZERO_EXT_EN is defined:
- In DECODE, opcodes 0x0C (andi) and 0x0D (ori) go to ADDIEX.
- In ADDIEX and ADDIWB for these opcodes, ext_sel=1 and ADDIEX uses alu_op=11.
REQ-028 SHALL, without ZERO_EXT_EN, treat 0x0C and 0x0D as illegal (REQ-011) and tie ext_sel to constant 0.

Verification
REQ-029 SHALL cover: reset pulse mid-MEMRD with mem_ready=0 -> state=0 immediately and pc_en=ir_write=0 during reset.
REQ-030 SHALL cover: opcode=0x23, mem_ready=1 throughout -> states 0,1,2,3,4,0, and reg_write=1 with mem_to_reg=1 only in state 4.
REQ-031 SHALL cover: opcode=0x2B, mem_ready low for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, then FETCH.
REQ-032 SHALL cover: opcode=0x04 with zero=1 and then zero=0 -> pc_en=1 with pc_src=01 in BEQEX for the first case only.
REQ-033 SHALL cover: opcode=0x3F -> illegal=1 for one cycle in DECODE, then FETCH, with no reg_write or mem_write.
REQ-034 SHALL cover: opcode=0x0D -> with ZERO_EXT_EN, states 0,1,9,10,0 with ext_sel=1 and alu_op=11 in ADDIEX; without it, illegal=1 and ext_sel=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM with a memory handshake and async reset.
// Optional zero-extended andi/ori immediates are compiled in when ZERO_EXT_EN is defined.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       ext_sel,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state_reg;
  logic   decode_zext;
  logic   decode_legal;
  logic   zext_reg;

`ifdef ZERO_EXT_EN
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;

  assign decode_zext = (opcode == OP_ANDI) || (opcode == OP_ORI);

  // Opcode is only looked at in DECODE, so remember the extension mode for ADDIEX/ADDIWB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zext_reg <= 1'b0;
    end else if (state_reg == DECODE) begin
      zext_reg <= decode_zext;
    end
  end
`else
  assign decode_zext = 1'b0;
  assign zext_reg    = 1'b0;
`endif

  assign decode_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                        (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J) ||
                        decode_zext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      case (state_reg)
        FETCH:   if (mem_ready) state_reg <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_reg <= MEMADR;
            OP_RTYPE:     state_reg <= RTYPEEX;
            OP_BEQ:       state_reg <= BEQEX;
            OP_ADDI:      state_reg <= ADDIEX;
            OP_J:         state_reg <= JEX;
            default:      state_reg <= decode_zext ? ADDIEX : FETCH;
          endcase
        end
        MEMADR:  state_reg <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (mem_ready) state_reg <= MEMWB;
        MEMWR:   if (mem_ready) state_reg <= FETCH;
        RTYPEEX: state_reg <= RTYPEWB;
        ADDIEX:  state_reg <= ADDIWB;
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign state   = state_reg;
  assign illegal = (state_reg == DECODE) && !decode_legal;

  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    ext_sel    = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // Reset holds the state at FETCH, so the handshake-gated writes must also see reset.
        ir_write  = mem_ready && !reset;
        pc_en     = mem_ready && !reset;
      end
      DECODE: begin
        alu_src_b = 2'b11;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = zext_reg ? 2'b11 : 2'b00;
        ext_sel   = zext_reg;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        ext_sel   = zext_reg;
      end
      JEX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
